// File: rtl/block_shift_pipe_if.sv
// Stream interface for block_shift_pipe: input beat, flush and result handshake.
// The producer/consumer side uses the master modport, the shifter uses slave.
interface block_shift_pipe_if #(
  parameter int unsigned ELMS  = 8,
  parameter int unsigned DATA  = 8,
  parameter int unsigned SHAMT = $clog2(ELMS + 1)
) ();
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [ELMS-1:0][DATA-1:0]  in_data;
  logic [SHAMT-1:0]           in_shamt;
  logic                       in_right;
  logic                       in_rotate;
  logic [DATA-1:0]            fill_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [ELMS-1:0][DATA-1:0]  out_data;

  modport master (
    output flush, in_valid, in_data, in_shamt, in_right, in_rotate, fill_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  flush, in_valid, in_data, in_shamt, in_right, in_rotate, fill_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/block_shift_pipe.sv
// Pipelined block shifter/rotator: one registered stage per shift-amount bit,
// stage k moving the vector by 2^k elements when its shamt bit is set.
// Optional feature macro: BLOCK_SHIFT_PIPE_FILL_EN (fill element taken from
// fill_data and carried with the beat; otherwise the fill element is 0).
module block_shift_pipe #(
  parameter int unsigned ELMS  = 8,
  parameter int unsigned DATA  = 8,
  parameter int unsigned SHAMT = $clog2(ELMS + 1)
) (
  input  logic              clk,
  input  logic              reset_,
  block_shift_pipe_if.slave bus
);

  localparam int unsigned IDXW = (ELMS > 1) ? $clog2(ELMS) : 1;

  typedef logic [ELMS-1:0][DATA-1:0] vec_t;
  typedef logic [SHAMT-1:0]          sh_t;

  // Move the vector by s elements. Rotation wraps by s mod ELMS; a shift
  // brings in the fill element and leaves all-fill once s reaches ELMS.
  function automatic vec_t move(input vec_t d, input int unsigned s, input logic right,
                                input logic rotate, input logic [DATA-1:0] fill);
    vec_t        r;
    int unsigned rs;
    int unsigned src;
    logic        inb;
    logic [IDXW-1:0] idx;
    rs = s % ELMS;
    for (int unsigned i = 0; i < ELMS; i++) begin
      if (rotate) begin
        src = right ? (i + rs) % ELMS : (i + ELMS - rs) % ELMS;
        inb = 1'b1;
      end else if (right) begin
        src = i + s;
        inb = (i + s) < ELMS;
      end else begin
        src = i - s;
        inb = i >= s;
      end
      idx  = IDXW'(src);
      r[i] = inb ? d[idx] : fill;
    end
    return r;
  endfunction

  logic [SHAMT-1:0] valid_q;
  vec_t             data_q   [SHAMT];
  sh_t              sh_q     [SHAMT];
  logic             right_q  [SHAMT];
  logic             rotate_q [SHAMT];

  logic [SHAMT:0]   ready;
  logic             in_ready;
  logic             up_valid  [SHAMT];
  vec_t             up_data   [SHAMT];
  sh_t              up_sh     [SHAMT];
  logic             up_right  [SHAMT];
  logic             up_rotate [SHAMT];
  logic [DATA-1:0]  up_fill   [SHAMT];
  vec_t             moved     [SHAMT];

`ifdef BLOCK_SHIFT_PIPE_FILL_EN
  logic [DATA-1:0]  fill_q    [SHAMT];
`else
  logic             unused_fill;
  assign unused_fill = ^bus.fill_data;
`endif

  // Stall chain: a stage can take new contents if empty or if it drains downstream.
  always_comb begin
    ready        = '0;
    ready[SHAMT] = bus.out_ready;
    for (int k = SHAMT - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] || ready[k+1];
    end
  end

  assign in_ready      = ready[0] && !bus.flush;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q[SHAMT-1];
  assign bus.out_data  = data_q[SHAMT-1];

  // Per-stage inputs (input port or previous stage) and the conditional move.
  always_comb begin
    up_valid[0]  = bus.in_valid && in_ready;
    up_data[0]   = bus.in_data;
    up_sh[0]     = bus.in_shamt;
    up_right[0]  = bus.in_right;
    up_rotate[0] = bus.in_rotate;
`ifdef BLOCK_SHIFT_PIPE_FILL_EN
    up_fill[0]   = bus.fill_data;
`else
    up_fill[0]   = '0;
`endif
    for (int k = 1; k < SHAMT; k++) begin
      up_valid[k]  = valid_q[k-1];
      up_data[k]   = data_q[k-1];
      up_sh[k]     = sh_q[k-1];
      up_right[k]  = right_q[k-1];
      up_rotate[k] = rotate_q[k-1];
`ifdef BLOCK_SHIFT_PIPE_FILL_EN
      up_fill[k]   = fill_q[k-1];
`else
      up_fill[k]   = '0;
`endif
    end
    for (int k = 0; k < SHAMT; k++) begin
      moved[k] = up_sh[k][k] ? move(up_data[k], 32'd1 << k, up_right[k], up_rotate[k],
                                    up_fill[k])
                             : up_data[k];
    end
  end

  // Stage registers: flush only kills valid bits; payload loads with a valid beat.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      valid_q <= '0;
      for (int k = 0; k < SHAMT; k++) begin
        data_q[k]   <= '0;
        sh_q[k]     <= '0;
        right_q[k]  <= 1'b0;
        rotate_q[k] <= 1'b0;
`ifdef BLOCK_SHIFT_PIPE_FILL_EN
        fill_q[k]   <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < SHAMT; k++) begin
        if (bus.flush) begin
          valid_q[k] <= 1'b0;
        end else if (ready[k]) begin
          valid_q[k] <= up_valid[k];
        end
        if (ready[k] && up_valid[k]) begin
          data_q[k]   <= moved[k];
          sh_q[k]     <= up_sh[k];
          right_q[k]  <= up_right[k];
          rotate_q[k] <= up_rotate[k];
`ifdef BLOCK_SHIFT_PIPE_FILL_EN
          fill_q[k]   <= up_fill[k];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_block_shift_pipe.sv
// Directed bench for block_shift_pipe (ELMS=8, DATA=8): table of single beats,
// then back-pressure, flush, mid-stream reset and a full mode/shamt sweep.
module tb_block_shift_pipe;

  localparam logic [63:0] IN_DATA = 64'h0807060504030201;

  logic clk;
  logic reset_;
  int   n_checks;
  int   n_fail;

  block_shift_pipe_if #(.ELMS(8), .DATA(8)) bus ();

  block_shift_pipe #(.ELMS(8), .DATA(8)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  sh;
    logic        right;
    logic        rot;
    logic [7:0]  fill;
    logic [63:0] exp;
  } vec_rec_t;

  vec_rec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] efill(input logic [7:0] f);
`ifdef BLOCK_SHIFT_PIPE_FILL_EN
    return f;
`else
    return f & 8'h00;
`endif
  endfunction

  // Reference: apply the whole shift amount in one go.
  function automatic logic [63:0] model(input logic [3:0] sh, input logic right,
                                        input logic rot, input logic [7:0] fill);
    logic [63:0] d;
    logic [63:0] r;
    int s, j;
    d = IN_DATA;
    s = int'(sh);
    for (int i = 0; i < 8; i++) begin
      if (rot) begin
        j = right ? (i + s) % 8 : (i + 8 - (s % 8)) % 8;
        r[8*i +: 8] = d[8*j +: 8];
      end else begin
        j = right ? i + s : i - s;
        r[8*i +: 8] = (j >= 0 && j < 8) ? d[8*j +: 8] : fill;
      end
    end
    return r;
  endfunction

  task automatic drive(input logic [3:0] sh, input logic right, input logic rot,
                       input logic [7:0] fill);
    bus.in_valid  = 1'b1;
    bus.in_data   = IN_DATA;
    bus.in_shamt  = sh;
    bus.in_right  = right;
    bus.in_rotate = rot;
    bus.fill_data = fill;
  endtask

  // One beat with out_ready=1: latency, data and single-cycle valid. Starts/ends at negedge.
  task automatic run_beat(input string name, input logic [3:0] sh, input logic right,
                          input logic rot, input logic [7:0] fill, input logic [63:0] exp);
    int lat;
    bus.out_ready = 1'b1;
    drive(sh, right, rot, fill);
    #1;
    check({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd3);
    check({name, " data"}, bus.out_data, exp);
    @(posedge clk);
    @(negedge clk);
    check({name, " valid drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic backpressure();
    int acc;
    int outs;
    logic hs;
    acc  = 0;
    outs = 0;
    for (int cyc = 0; cyc < 40 && outs < 6; cyc++) begin
      bus.out_ready = (cyc >= 6);
      if (acc < 6) drive(4'(acc), 1'b0, 1'b0, 8'h00);
      else bus.in_valid = 1'b0;
      #1;
      if (cyc < 6) check($sformatf("bp in_ready c%0d", cyc), 64'(bus.in_ready),
                         64'(cyc < 4));
      if (cyc == 4 || cyc == 5) begin
        check($sformatf("bp stall valid c%0d", cyc), 64'(bus.out_valid), 64'd1);
        check($sformatf("bp stall data c%0d", cyc), bus.out_data, model(4'd0, 1'b0, 1'b0, 8'h00));
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp out %0d", outs), bus.out_data, model(4'(outs), 1'b0, 1'b0, 8'h00));
        outs++;
      end
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (hs) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("bp accepted", 64'(acc), 64'd6);
    check("bp delivered", 64'(outs), 64'd6);
  endtask

  task automatic flush_seq();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'(i + 1), 1'b0, 1'b1, 8'h00);
      #1;
      check($sformatf("fl accept %0d", i), 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.flush = 1'b1;
    drive(4'd5, 1'b0, 1'b0, 8'h00);
    #1;
    check("fl in_ready", 64'(bus.in_ready), 64'd0);
    check("fl out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fl empty %0d", i), 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    run_beat("fl next", 4'd3, 1'b1, 1'b0, 8'h00, model(4'd3, 1'b1, 1'b0, 8'h00));
  endtask

  task automatic reset_seq();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'(i), 1'b1, 1'b1, 8'h00);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("rst full", 64'(bus.out_valid), 64'd1);
    #2;
    reset_ = 1'b0;
    #1;
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst out_data", bus.out_data, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] exp_fill2;
    n_checks = 0;
    n_fail   = 0;
`ifdef BLOCK_SHIFT_PIPE_FILL_EN
    exp_fill2 = 64'h060504030201AAAA;
`else
    exp_fill2 = 64'h0605040302010000;
`endif
    tbl[0] = '{sh: 4'd3,  right: 1'b0, rot: 1'b0, fill: 8'h00, exp: 64'h0504030201000000};
    tbl[1] = '{sh: 4'd2,  right: 1'b1, rot: 1'b1, fill: 8'h00, exp: 64'h0201080706050403};
    tbl[2] = '{sh: 4'd8,  right: 1'b0, rot: 1'b1, fill: 8'h00, exp: 64'h0807060504030201};
    tbl[3] = '{sh: 4'd9,  right: 1'b0, rot: 1'b1, fill: 8'h00, exp: 64'h0706050403020108};
    tbl[4] = '{sh: 4'd8,  right: 1'b1, rot: 1'b0, fill: 8'h00, exp: 64'h0000000000000000};
    tbl[5] = '{sh: 4'd15, right: 1'b1, rot: 1'b0, fill: 8'h00, exp: 64'h0000000000000000};
    tbl[6] = '{sh: 4'd2,  right: 1'b0, rot: 1'b0, fill: 8'hAA, exp: exp_fill2};
    tbl[7] = '{sh: 4'd1,  right: 1'b1, rot: 1'b0, fill: 8'h00, exp: 64'h0008070605040302};
    tbl[8] = '{sh: 4'd7,  right: 1'b1, rot: 1'b1, fill: 8'hAA, exp: 64'h0706050403020108};
    tbl[9] = '{sh: 4'd0,  right: 1'b0, rot: 1'b0, fill: 8'hAA, exp: 64'h0807060504030201};

    reset_        = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_right  = 1'b0;
    bus.in_rotate = 1'b0;
    bus.fill_data = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset out_data", bus.out_data, 64'd0);
    @(negedge clk);
    reset_ = 1'b1;
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_beat($sformatf("vec%0d", i), tbl[i].sh, tbl[i].right, tbl[i].rot, tbl[i].fill,
               tbl[i].exp);
    end

    backpressure();
    flush_seq();
    reset_seq();

    for (int mode = 0; mode < 4; mode++) begin
      for (int s = 0; s <= 8; s++) begin
        run_beat($sformatf("sweep m%0d s%0d", mode, s), 4'(s), mode[0], mode[1], 8'hAA,
                 model(4'(s), mode[0], mode[1], efill(8'hAA)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
